fetch_queue: RTL and testbench

Parametrised instruction prefetch queue that replaces the single-entry IF/ID pipeline register between instruction fetch and decode. It buffers up to DEPTH fetched instruction/PC pairs. Decode stalls and fetch-side backpressure become valid/ready handshakes. A branch/jump redirect (pcsrc) flushes all buffered entries in one cycle. An empty or flushed queue presents a canonical NOP (0x00000013) to decode.

---
 rtl/fetch_queue_if.sv | 26 ++
 rtl/fetch_queue.sv | 86 ++++++++
 tb/tb_fetch_queue.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_if.sv
// Fetch-to-decode handshake bundle for fetch_queue: the push channel from fetch
// and the pop channel to decode. The slave modport is the queue's view.
interface fetch_queue_if #(
  parameter int IW = 32,
  parameter int AW = 32
);
  logic          in_valid;
  logic          in_ready;
  logic [IW-1:0] in_instr;
  logic [AW-1:0] in_pc;
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] out_instr;
  logic [AW-1:0] out_pc;
  logic [AW-1:0] out_pcplus4;

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_instr, out_pc, out_pcplus4
  );

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_instr, out_pc, out_pcplus4
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction prefetch queue between fetch and decode; flush/reset empty it in one
// cycle. Optional empty-queue pass-through enabled by defining FQ_BYPASS_EN.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int IW    = 32,
  parameter int AW    = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  fetch_queue_if.slave             fq,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [IW-1:0] NOP = IW'(32'h0000_0013);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("fetch_queue: DEPTH must be a power of two and at least 2");
  end

  logic [IW-1:0] mem_instr [DEPTH];
  logic [AW-1:0] mem_pc    [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          not_empty;
  logic          bypass;
  logic          push;
  logic          pop;

  assign not_empty = (count != '0);

`ifdef FQ_BYPASS_EN
  assign bypass = !not_empty && fq.in_valid && !flush;
`else
  assign bypass = 1'b0;
`endif

  // A full queue refuses pushes even when decode pops in the same cycle.
  assign fq.in_ready  = (count < CW'(DEPTH));
  assign fq.out_valid = not_empty || bypass;

  // A bypassed word taken by decode never enters storage.
  assign push = fq.in_valid && fq.in_ready && !(bypass && fq.out_ready);
  assign pop  = not_empty && fq.out_ready;

  always_comb begin
    fq.out_instr = NOP;
    fq.out_pc    = '0;
    if (bypass) begin
      fq.out_instr = fq.in_instr;
      fq.out_pc    = fq.in_pc;
    end else if (not_empty) begin
      fq.out_instr = mem_instr[rd_ptr];
      fq.out_pc    = mem_pc[rd_ptr];
    end
  end

  assign fq.out_pcplus4 = fq.out_pc + AW'(4);

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      // NOTE: non-blocking updates so every register samples pre-edge values.
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; entries are only observable through
  // count, which is reset, so stale contents can never reach decode.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_instr[wr_ptr] <= fq.in_instr;
      mem_pc[wr_ptr]    <= fq.in_pc;
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios pinned with literal
// values, then randomized traffic against a queue-based reference model.
module tb_fetch_queue;
  localparam int DEPTH = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } entry_t;

  logic       clk;
  logic       reset;
  logic       flush;
  logic [2:0] count;

  fetch_queue_if #(.IW(32), .AW(32)) fq ();

  fetch_queue #(.DEPTH(DEPTH), .IW(32), .AW(32)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .fq    (fq),
    .count (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int     checks = 0;
  int     errors = 0;
  entry_t q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                       input logic ordy, input logic fl, input logic rst);
    fq.in_valid  = v;
    fq.in_instr  = instr;
    fq.in_pc     = pc;
    fq.out_ready = ordy;
    flush        = fl;
    reset        = rst;
  endtask

  // Compare against the model at the falling edge, then advance the model with
  // the inputs that the coming rising edge will see.
  task automatic tick();
    entry_t      head;
    bit          byp;
    bit          do_push;
    bit          do_pop;
    int          n;
    logic [31:0] p4;
    @(negedge clk);
    n = q.size();
`ifdef FQ_BYPASS_EN
    byp = (n == 0) && fq.in_valid && !flush;
`else
    byp = 1'b0;
`endif
    if (byp)         head = '{fq.in_instr, fq.in_pc};
    else if (n != 0) head = q[0];
    else             head = '{NOP, 32'h0};
    p4 = head.pc + 32'd4;
    check("count",       64'(count),          64'(n));
    check("in_ready",    64'(fq.in_ready),    64'(n < DEPTH));
    check("out_valid",   64'(fq.out_valid),   64'((n != 0) || byp));
    check("out_instr",   64'(fq.out_instr),   64'(head.instr));
    check("out_pc",      64'(fq.out_pc),      64'(head.pc));
    check("out_pcplus4", 64'(fq.out_pcplus4), 64'(p4));
    if (reset || flush) begin
      q.delete();
    end else begin
      do_push = fq.in_valid && (n < DEPTH) && !(byp && fq.out_ready);
      do_pop  = (n != 0) && fq.out_ready;
      if (do_pop)  void'(q.pop_front());
      if (do_push) q.push_back('{fq.in_instr, fq.in_pc});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 1; i++) begin
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
      tick();
    end
  endtask

  initial begin
    logic [31:0] pc_next;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    tick();

    // Idle after reset.
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    #1;
    check("rst_out_valid", 64'(fq.out_valid),   64'd0);
    check("rst_out_instr", 64'(fq.out_instr),   64'h13);
    check("rst_out_pc",    64'(fq.out_pc),      64'd0);
    check("rst_pcplus4",   64'(fq.out_pcplus4), 64'd4);
    check("rst_count",     64'(count),          64'd0);
    check("rst_in_ready",  64'(fq.in_ready),    64'd1);
    tick();

    // Fill to full with decode stalled; the fifth word is refused.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'hA000_0000 + 32'(i), 32'(i * 4), 1'b0, 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 32'hA000_0004, 32'h10, 1'b0, 1'b0, 1'b0);
    #1;
    check("full_count",    64'(count),       64'd4);
    check("full_in_ready", 64'(fq.in_ready), 64'd0);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
      #1;
      check("pop_pc",      64'(fq.out_pc),      64'(i * 4));
      check("pop_pcplus4", 64'(fq.out_pcplus4), 64'(i * 4 + 4));
      tick();
    end

    // Streaming across the pointer wrap.
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'hB000_0000 + 32'(i), 32'h1000 + 32'(i * 4), 1'b1, 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    #1;
`ifdef FQ_BYPASS_EN
    check("stream_count", 64'(count), 64'd0);
`else
    check("stream_count", 64'(count), 64'd1);
    check("stream_last",  64'(fq.out_pc), 64'h1024);
`endif
    drain();

    // Flush with three entries, colliding with a push and a pop.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'hC000_0000 + 32'(i), 32'h2000 + 32'(i * 4), 1'b0, 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 32'hDEAD_BEEF, 32'h3000, 1'b1, 1'b1, 1'b0);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    #1;
    check("flush_count",     64'(count),        64'd0);
    check("flush_out_valid", 64'(fq.out_valid), 64'd0);
    check("flush_in_ready",  64'(fq.in_ready),  64'd1);
    tick();

    // Reset while full and mid-transfer, then one push.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'hE000_0000 + 32'(i), 32'h4000 + 32'(i * 4), 1'b0, 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 32'hE000_0009, 32'h4100, 1'b1, 1'b0, 1'b1);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    #1;
    check("rst2_out_valid", 64'(fq.out_valid), 64'd0);
    check("rst2_out_instr", 64'(fq.out_instr), 64'h13);
    check("rst2_count",     64'(count),        64'd0);
    drive(1'b1, 32'h1234_5678, 32'h200, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    #1;
    check("rst2_push_pc",    64'(fq.out_pc),    64'h200);
    check("rst2_push_instr", 64'(fq.out_instr), 64'h1234_5678);
    check("rst2_push_count", 64'(count),        64'd1);
    drain();

    // Empty-queue latency.
    drive(1'b1, 32'h0000_0093, 32'h100, 1'b1, 1'b0, 1'b0);
    #1;
`ifdef FQ_BYPASS_EN
    check("byp_out_valid", 64'(fq.out_valid),   64'd1);
    check("byp_out_pc",    64'(fq.out_pc),      64'h100);
    check("byp_pcplus4",   64'(fq.out_pcplus4), 64'h104);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    #1;
    check("byp_count", 64'(count), 64'd0);
`else
    check("lat_out_valid", 64'(fq.out_valid), 64'd0);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    #1;
    check("lat_out_pc", 64'(fq.out_pc), 64'h100);
    check("lat_count",  64'(count),     64'd1);
`endif
    tick();
    drain();

    // PC+4 wraps modulo 2^32.
    drive(1'b1, 32'h0000_0013, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    #1;
    check("wrap_pc",      64'(fq.out_pc),      64'hFFFF_FFFC);
    check("wrap_pcplus4", 64'(fq.out_pcplus4), 64'd0);
    tick();
    drain();

    // Randomized traffic against the model.
    pc_next = 32'h8000;
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(99) < 70, $urandom, pc_next, $urandom_range(99) < 60,
            $urandom_range(99) < 3, $urandom_range(99) < 1);
      if (fq.in_valid) pc_next = pc_next + 32'd4;
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
